// File: rtl/gen_prng_pkg.sv
// Shared types and helpers for the bounded pseudo-random generator.
// Holds the FSM encoding, the LFSR step function and the default 8-bit maximal mask.
package gen_prng_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } fsm_e;

    localparam int          DEF_WIDTH = 8;
    localparam logic [7:0]  DEF_TAPS  = 8'hB8;

    // Fibonacci step on a 64-bit carrier; callers zero-extend and truncate to their width.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state, input logic [63:0] taps);
        logic fb;
        fb = ^(state & taps);
        return (state << 1) | {63'd0, fb};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and all-zero lock-up recovery.
// Loading zero selects the built-in seed so the register never starts stuck.
module lfsr_core
    import gen_prng_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == '0) begin
            state_d = SEED;
        end else if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_d = WIDTH'(lfsr_next(64'(state_q), 64'(TAPS)));
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/gen_prng.sv
// Bounded random number source: LFSR plus rejection sampling into [MIN..MAX].
// One result per REQ; after MAX_TRIES rejections the result falls back to MIN with TO set.
module gen_prng
    import gen_prng_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
    parameter int               OUT_W     = 4,
    parameter int               MIN       = 1,
    parameter int               MAX       = 11,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               MAX_TRIES = 16
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             ENC,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED_IN,
    input  logic             REQ,
    output logic             BUSY,
    output logic             DV,
    output logic [OUT_W-1:0] DO,
    output logic             TO
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    fsm_e             fsm_q, fsm_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0] do_q, do_d;
    logic             dv_q, dv_d;
    logic             to_q, to_d;

    logic             lfsr_step;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_state;
    logic [OUT_W-1:0] cand;
    logic             in_range;
    logic [TRY_W:0]   tries_inc;
    logic             last_try;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .CLK      (CLK),
        .RES      (RES),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (SEED_IN),
        .state    (lfsr_state)
    );

    assign cand      = OUT_W'(lfsr_state);
    assign in_range  = (cand >= OUT_W'(MIN)) && (cand <= OUT_W'(MAX));
    assign tries_inc = {1'b0, tries_q} + (TRY_W+1)'(1);
    assign last_try  = (tries_inc == (TRY_W+1)'(MAX_TRIES));

    always_comb begin
        fsm_d     = fsm_q;
        tries_d   = tries_q;
        do_d      = do_q;
        dv_d      = 1'b0;
        to_d      = to_q;
        lfsr_step = 1'b0;
        lfsr_load = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (LOAD) begin
                    lfsr_load = 1'b1;
                end else if (REQ) begin
                    lfsr_step = 1'b1;
                    tries_d   = '0;
                    fsm_d     = SEARCH;
                end else if (ENC) begin
                    lfsr_step = 1'b1;
                end
            end
            SEARCH: begin
                if (LOAD) begin
                    // Abort without a result; the fresh seed takes effect immediately.
                    lfsr_load = 1'b1;
                    fsm_d     = IDLE;
                end else if (in_range) begin
                    do_d      = cand;
                    dv_d      = 1'b1;
                    to_d      = 1'b0;
                    lfsr_step = 1'b1;
                    fsm_d     = IDLE;
                end else if (last_try) begin
                    do_d      = OUT_W'(MIN);
                    dv_d      = 1'b1;
                    to_d      = 1'b1;
                    lfsr_step = 1'b1;
                    fsm_d     = IDLE;
                end else begin
                    tries_d   = (&tries_q) ? tries_q : tries_q + TRY_W'(1);
                    lfsr_step = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            fsm_q   <= IDLE;
            tries_q <= '0;
            do_q    <= '0;
            dv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            tries_q <= tries_d;
            do_q    <= do_d;
            dv_q    <= dv_d;
            to_q    <= to_d;
        end
    end

    assign BUSY = (fsm_q == SEARCH);
    assign DV   = dv_q;
    assign DO   = do_q;
    assign TO   = to_q;

endmodule

// File: tb/tb_gen_prng.sv
// Directed bench for gen_prng: default instance plus a MAX_TRIES=1 instance sharing inputs.
module tb_gen_prng;

    logic       clk = 1'b0;
    logic       res;
    logic       enc;
    logic       load;
    logic [7:0] seed_in;
    logic       req;

    logic       busy0, dv0, to0;
    logic [3:0] do0;
    logic       busy1, dv1, to1;
    logic [3:0] do1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen_prng dut0 (
        .CLK(clk), .RES(res), .ENC(enc), .LOAD(load), .SEED_IN(seed_in), .REQ(req),
        .BUSY(busy0), .DV(dv0), .DO(do0), .TO(to0)
    );

    gen_prng #(.MAX_TRIES(1)) dut1 (
        .CLK(clk), .RES(res), .ENC(enc), .LOAD(load), .SEED_IN(seed_in), .REQ(req),
        .BUSY(busy1), .DV(dv1), .DO(do1), .TO(to1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        res = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; enc = 1'b0; load = 1'b0; seed_in = 8'h00; req = 1'b0;
        tick();
        tick();
        res = 1'b0;
        checks++; if (dv0 !== 1'b0)   begin errors++; $display("FAIL reset_dv got %b want 0", dv0); end
        checks++; if (do0 !== 4'd0)   begin errors++; $display("FAIL reset_do got %0d want 0", do0); end
        checks++; if (to0 !== 1'b0)   begin errors++; $display("FAIL reset_to got %b want 0", to0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    endtask

    // From seed 01: states 02, 08, 23 give results 2, 8, 3.
    task automatic test_basic();
        logic [3:0] exp_do [3];
        exp_do[0] = 4'd2; exp_do[1] = 4'd8; exp_do[2] = 4'd3;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            checks++; if (busy0 !== 1'b1 || dv0 !== 1'b0) begin errors++; $display("FAIL basic_busy%0d busy=%b dv=%b want busy=1 dv=0", i, busy0, dv0); end
            tick();
            checks++; if (dv0 !== 1'b1 || do0 !== exp_do[i] || to0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL basic_dv%0d dv=%b do=%0d to=%b busy=%b want dv=1 do=%0d to=0 busy=0", i, dv0, do0, to0, busy0, exp_do[i]);
            end
            tick();
            checks++; if (dv0 !== 1'b0 || do0 !== exp_do[i]) begin errors++; $display("FAIL basic_hold%0d dv=%b do=%0d want dv=0 do=%0d", i, dv0, do0, exp_do[i]); end
        end
    endtask

    // Seed 07: candidates 14, 13 rejected, 10 accepted; MAX_TRIES=1 times out on the first.
    task automatic test_reject(input logic enc_in_search);
        load = 1'b1; seed_in = 8'h07;
        tick();
        load = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        enc = enc_in_search;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL reject_busy_n got %b want 1", busy0); end
        tick();
        checks++; if (busy0 !== 1'b1 || dv0 !== 1'b0) begin errors++; $display("FAIL reject_busy_n1 busy=%b dv=%b want 1 0", busy0, dv0); end
        checks++; if (dv1 !== 1'b1 || do1 !== 4'd1 || to1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL timeout dv=%b do=%0d to=%b busy=%b want dv=1 do=1 to=1 busy=0", dv1, do1, to1, busy1);
        end
        tick();
        checks++; if (busy0 !== 1'b1 || dv0 !== 1'b0) begin errors++; $display("FAIL reject_busy_n2 busy=%b dv=%b want 1 0", busy0, dv0); end
        tick();
        checks++; if (dv0 !== 1'b1 || do0 !== 4'd10 || to0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL reject_dv dv=%b do=%0d to=%b busy=%b want dv=1 do=10 to=0 busy=0", dv0, do0, to0, busy0);
        end
        enc = 1'b0;
        tick();
    endtask

    task automatic test_load_zero();
        load = 1'b1; seed_in = 8'h00;
        tick();
        load = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++; if (dv0 !== 1'b1 || do0 !== 4'd2) begin errors++; $display("FAIL load_zero dv=%b do=%0d want dv=1 do=2", dv0, do0); end
        tick();
    endtask

    // ENC three cycles from reset: 01 -> 08; REQ then steps to 11, candidate 1.
    task automatic test_enc();
        do_reset();
        enc = 1'b1;
        tick(); tick(); tick();
        enc = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++; if (dv0 !== 1'b1 || do0 !== 4'd1 || to0 !== 1'b0) begin errors++; $display("FAIL enc_idle dv=%b do=%0d to=%b want dv=1 do=1 to=0", dv0, do0, to0); end
        tick();
        test_reject(1'b1);
    endtask

    task automatic test_abort();
        logic [3:0] held;
        // Reset one cycle into a rejecting search.
        load = 1'b1; seed_in = 8'h07;
        tick();
        load = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        res = 1'b1;
        tick();
        res = 1'b0;
        checks++; if (busy0 !== 1'b0 || dv0 !== 1'b0 || do0 !== 4'd0) begin errors++; $display("FAIL abort_res busy=%b dv=%b do=%0d want 0 0 0", busy0, dv0, do0); end
        tick();
        checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL abort_res_nodv dv=%b want 0", dv0); end
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++; if (dv0 !== 1'b1 || do0 !== 4'd2) begin errors++; $display("FAIL abort_res_seed dv=%b do=%0d want dv=1 do=2", dv0, do0); end
        tick();
        // LOAD of zero one cycle into a rejecting search.
        held = do0;
        load = 1'b1; seed_in = 8'h07;
        tick();
        load = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        load = 1'b1; seed_in = 8'h00;
        tick();
        load = 1'b0;
        checks++; if (busy0 !== 1'b0 || dv0 !== 1'b0 || do0 !== held) begin errors++; $display("FAIL abort_load busy=%b dv=%b do=%0d want 0 0 %0d", busy0, dv0, do0, held); end
        tick();
        checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL abort_load_nodv dv=%b want 0", dv0); end
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++; if (dv0 !== 1'b1 || do0 !== 4'd2) begin errors++; $display("FAIL abort_load_seed dv=%b do=%0d want dv=1 do=2", dv0, do0); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic       exp_dv [6];
        logic [3:0] exp_do [6];
        exp_dv[0] = 1'b0; exp_dv[1] = 1'b1; exp_dv[2] = 1'b0; exp_dv[3] = 1'b1; exp_dv[4] = 1'b0; exp_dv[5] = 1'b1;
        exp_do[0] = 4'd0; exp_do[1] = 4'd2; exp_do[2] = 4'd2; exp_do[3] = 4'd8; exp_do[4] = 4'd8; exp_do[5] = 4'd3;
        do_reset();
        req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (dv0 !== exp_dv[i] || do0 !== exp_do[i]) begin
                errors++; $display("FAIL b2b_%0d dv=%b do=%0d want dv=%b do=%0d", i, dv0, do0, exp_dv[i], exp_do[i]);
            end
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject(1'b0);
        test_load_zero();
        test_enc();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
